// File: rtl/bus_sequencer.sv
// rtl/bus_sequencer.sv - single-issue register-transfer sequencer driving a shared data bus
module bus_sequencer #(
  parameter int STORE_TIMEOUT = 15,
  parameter int CNT_W         = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [2:0]       cmd_src,
  input  logic [2:0]       cmd_dst,
  input  logic [7:0]       cmd_imm,
  output logic             read_data,
  output logic             write_data,
  output logic [2:0]       input_select,
  output logic [2:0]       output_select,
  inout  wire  [7:0]       data_bus,
  output logic             store_valid,
  output logic [7:0]       store_data,
  input  logic             store_ready,
  input  logic             err_clear,
  output logic             timeout_err,
  output logic [CNT_W-1:0] xfer_count
);

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_LOADI = 2'b01;
  localparam logic [1:0] OP_MOV   = 2'b10;
  localparam logic [1:0] OP_STORE = 2'b11;

  // The wait counter only ever holds 0 .. STORE_TIMEOUT-1.
  localparam int TW = (STORE_TIMEOUT > 1) ? $clog2(STORE_TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(STORE_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    STORE_WAIT
  } state_t;

  state_t          state;
  state_t          next_state;

  // Latched command; every strobe below is decoded from these, never from cmd_*.
  logic [1:0]      op_q;
  logic [2:0]      src_q;
  logic [2:0]      dst_q;
  logic [7:0]      imm_q;

  logic [TW-1:0]   tmo_cnt;
  logic            drive_bus;
  logic            count_inc;
  logic            tmo_hit;
  logic            accept;
  logic            store_capture;

  // The bus is only ever driven while a LOADI executes; write_data is never
  // asserted in that case, so the register file and this block cannot clash.
  assign data_bus = drive_bus ? imm_q : 8'hzz;

  assign accept        = (state == IDLE) && cmd_valid;
  assign store_capture = (state == EXEC) && (op_q == OP_STORE);

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and strobe decode from the current state and the latched command.
  always_comb begin
    next_state    = state;
    cmd_ready     = 1'b0;
    read_data     = 1'b0;
    write_data    = 1'b0;
    input_select  = 3'd0;
    output_select = 3'd0;
    drive_bus     = 1'b0;
    store_valid   = 1'b0;
    count_inc     = 1'b0;
    tmo_hit       = 1'b0;
    unique case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          next_state = EXEC;
        end
      end
      EXEC: begin
        next_state = IDLE;
        case (op_q)
          OP_LOADI: begin
            drive_bus    = 1'b1;
            read_data    = 1'b1;
            input_select = dst_q;
            count_inc    = 1'b1;
          end
          OP_MOV: begin
            // src == dst is a legal no-change transfer and still counts.
            write_data    = 1'b1;
            output_select = src_q;
            read_data     = 1'b1;
            input_select  = dst_q;
            count_inc     = 1'b1;
          end
          OP_STORE: begin
            write_data    = 1'b1;
            output_select = src_q;
            next_state    = STORE_WAIT;
          end
          default: begin
            // NOP: a silent cycle, nothing counted.
          end
        endcase
      end
      STORE_WAIT: begin
        store_valid = 1'b1;
        // A consumer that shows up on the last allowed cycle still wins.
        if (store_ready) begin
          next_state = IDLE;
          count_inc  = 1'b1;
        end else if (tmo_cnt == TMO_LAST) begin
          next_state = IDLE;
          tmo_hit    = 1'b1;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Capture the command fields on acceptance.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      op_q  <= OP_NOP;
      src_q <= 3'd0;
      dst_q <= 3'd0;
      imm_q <= 8'h00;
    end else if (accept) begin
      op_q  <= cmd_op;
      src_q <= cmd_src;
      dst_q <= cmd_dst;
      imm_q <= cmd_imm;
    end
  end

  // Sample the source register off the bus at the edge that closes a STORE's EXEC cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      store_data <= 8'h00;
    end else if (store_capture) begin
      store_data <= data_bus;
    end
  end

  // Count cycles spent waiting without a consumer; zero whenever not staying in STORE_WAIT.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tmo_cnt <= '0;
    end else if ((state == STORE_WAIT) && (next_state == STORE_WAIT)) begin
      tmo_cnt <= tmo_cnt + TW'(1);
    end else begin
      tmo_cnt <= '0;
    end
  end

  // Sticky abandon flag; a new abandon beats a simultaneous clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      timeout_err <= 1'b0;
    end else if (tmo_hit) begin
      timeout_err <= 1'b1;
    end else if (err_clear) begin
      timeout_err <= 1'b0;
    end
  end

  // Completed-transfer counter, wrapping naturally at 2^CNT_W.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      xfer_count <= '0;
    end else if (count_inc) begin
      xfer_count <= xfer_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_bus_sequencer.sv
// tb/tb_bus_sequencer.sv - directed self-checking bench for bus_sequencer
module tb_bus_sequencer;

  localparam logic [1:0] NOP   = 2'b00;
  localparam logic [1:0] LOADI = 2'b01;
  localparam logic [1:0] MOV   = 2'b10;
  localparam logic [1:0] STORE = 2'b11;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [2:0] cmd_src = 3'd0;
  logic [2:0] cmd_dst = 3'd0;
  logic [7:0] cmd_imm = 8'h00;
  logic       read_data;
  logic       write_data;
  logic [2:0] input_select;
  logic [2:0] output_select;
  wire  [7:0] data_bus;
  logic       store_valid;
  logic [7:0] store_data;
  logic       store_ready = 1'b0;
  logic       err_clear = 1'b0;
  logic       timeout_err;
  logic [7:0] xfer_count;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] regs [8];

  bus_sequencer #(.STORE_TIMEOUT(15), .CNT_W(8)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_imm(cmd_imm),
    .read_data(read_data), .write_data(write_data),
    .input_select(input_select), .output_select(output_select),
    .data_bus(data_bus),
    .store_valid(store_valid), .store_data(store_data), .store_ready(store_ready),
    .err_clear(err_clear), .timeout_err(timeout_err), .xfer_count(xfer_count)
  );

  always #5 clock = ~clock;

  // Register file model: drives the selected register when asked, otherwise
  // holds the bus at 0x00 except while the sequencer loads an immediate.
  assign data_bus = (write_data || !read_data) ? (write_data ? regs[output_select] : 8'h00) : 8'hzz;

  // Register file write port.
  always @(posedge clock) begin
    if (read_data) regs[input_select] <= data_bus;
  end

  // Present a command at an IDLE negedge; returns at the negedge of its EXEC cycle
  // with the cmd_* inputs scrambled to show they were latched.
  task automatic issue(input logic [1:0] op, input logic [2:0] src, input logic [2:0] dst, input logic [7:0] imm);
    cmd_op = op; cmd_src = src; cmd_dst = dst; cmd_imm = imm; cmd_valid = 1'b1;
    vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL issue_ready: got %b want 1", cmd_ready); end
    @(negedge clock);
    cmd_valid = 1'b0; cmd_op = ~op; cmd_src = ~src; cmd_dst = ~dst; cmd_imm = ~imm;
  endtask

  // Sit in STORE_WAIT counting valid cycles; raise store_ready on cycle ready_at (0 = never).
  task automatic wait_store(input int ready_at, input logic [7:0] want, output int n, output int bad);
    n = 0; bad = 0;
    while (store_valid === 1'b1 && n < 40) begin
      n++;
      if (store_data !== want) bad++;
      store_ready = (n == ready_at);
      @(negedge clock);
    end
    store_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    vectors++; if (read_data !== 1'b0) begin miscompares++; $display("FAIL rst_read_data: got %b want 0", read_data); end
    vectors++; if (write_data !== 1'b0) begin miscompares++; $display("FAIL rst_write_data: got %b want 0", write_data); end
    vectors++; if (input_select !== 3'd0 || output_select !== 3'd0) begin miscompares++; $display("FAIL rst_selects: got %0d/%0d want 0/0", input_select, output_select); end
    vectors++; if (store_valid !== 1'b0) begin miscompares++; $display("FAIL rst_store_valid: got %b want 0", store_valid); end
    vectors++; if (store_data !== 8'h00) begin miscompares++; $display("FAIL rst_store_data: got %h want 00", store_data); end
    vectors++; if (timeout_err !== 1'b0) begin miscompares++; $display("FAIL rst_timeout_err: got %b want 0", timeout_err); end
    vectors++; if (xfer_count !== 8'h00) begin miscompares++; $display("FAIL rst_xfer_count: got %h want 00", xfer_count); end
    vectors++; if (data_bus !== 8'h00) begin miscompares++; $display("FAIL rst_data_bus: got %h want 00", data_bus); end
    reset = 1'b0;
    @(negedge clock);
    vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL rst_cmd_ready: got %b want 1", cmd_ready); end
  endtask

  task automatic test_loadi();
    issue(LOADI, 3'd0, 3'd3, 8'hA5);
    vectors++; if (cmd_ready !== 1'b0) begin miscompares++; $display("FAIL loadi_exec_ready: got %b want 0", cmd_ready); end
    vectors++; if (read_data !== 1'b1 || write_data !== 1'b0) begin miscompares++; $display("FAIL loadi_strobes: got rd=%b wr=%b want rd=1 wr=0", read_data, write_data); end
    vectors++; if (input_select !== 3'd3) begin miscompares++; $display("FAIL loadi_input_select: got %0d want 3", input_select); end
    vectors++; if (data_bus !== 8'hA5) begin miscompares++; $display("FAIL loadi_data_bus: got %h want a5", data_bus); end
    @(negedge clock);
    vectors++; if (regs[3] !== 8'hA5) begin miscompares++; $display("FAIL loadi_reg3: got %h want a5", regs[3]); end
    vectors++; if (xfer_count !== 8'd1) begin miscompares++; $display("FAIL loadi_count: got %0d want 1", xfer_count); end
    vectors++; if (cmd_ready !== 1'b1 || read_data !== 1'b0) begin miscompares++; $display("FAIL loadi_back_idle: got ready=%b rd=%b want 1/0", cmd_ready, read_data); end
  endtask

  task automatic test_nop();
    issue(NOP, 3'd2, 3'd5, 8'h77);
    vectors++; if (read_data !== 1'b0 || write_data !== 1'b0) begin miscompares++; $display("FAIL nop_strobes: got rd=%b wr=%b want 0/0", read_data, write_data); end
    vectors++; if (data_bus !== 8'h00) begin miscompares++; $display("FAIL nop_data_bus: got %h want 00", data_bus); end
    @(negedge clock);
    vectors++; if (xfer_count !== 8'd1) begin miscompares++; $display("FAIL nop_count: got %0d want 1", xfer_count); end
  endtask

  task automatic test_mov();
    issue(LOADI, 3'd0, 3'd1, 8'h3C);
    @(negedge clock);
    issue(MOV, 3'd1, 3'd6, 8'hC3);
    vectors++; if (read_data !== 1'b1 || write_data !== 1'b1) begin miscompares++; $display("FAIL mov_strobes: got rd=%b wr=%b want 1/1", read_data, write_data); end
    vectors++; if (output_select !== 3'd1 || input_select !== 3'd6) begin miscompares++; $display("FAIL mov_selects: got %0d/%0d want 1/6", output_select, input_select); end
    vectors++; if (data_bus !== 8'h3C) begin miscompares++; $display("FAIL mov_data_bus: got %h want 3c", data_bus); end
    @(negedge clock);
    vectors++; if (regs[6] !== 8'h3C) begin miscompares++; $display("FAIL mov_reg6: got %h want 3c", regs[6]); end
    vectors++; if (xfer_count !== 8'd3) begin miscompares++; $display("FAIL mov_count: got %0d want 3", xfer_count); end
    issue(MOV, 3'd6, 3'd6, 8'h00);
    vectors++; if (output_select !== 3'd6 || input_select !== 3'd6) begin miscompares++; $display("FAIL mov_self_selects: got %0d/%0d want 6/6", output_select, input_select); end
    @(negedge clock);
    vectors++; if (regs[6] !== 8'h3C || xfer_count !== 8'd4) begin miscompares++; $display("FAIL mov_self: got reg=%h cnt=%0d want 3c/4", regs[6], xfer_count); end
  endtask

  task automatic test_store();
    int n, bad;
    issue(STORE, 3'd6, 3'd0, 8'h00);
    vectors++; if (write_data !== 1'b1 || read_data !== 1'b0) begin miscompares++; $display("FAIL store_exec_strobes: got rd=%b wr=%b want 0/1", read_data, write_data); end
    vectors++; if (output_select !== 3'd6) begin miscompares++; $display("FAIL store_output_select: got %0d want 6", output_select); end
    vectors++; if (store_valid !== 1'b0) begin miscompares++; $display("FAIL store_exec_valid: got %b want 0", store_valid); end
    @(negedge clock);
    vectors++; if (cmd_ready !== 1'b0) begin miscompares++; $display("FAIL store_wait_ready: got %b want 0", cmd_ready); end
    wait_store(5, 8'h3C, n, bad);
    vectors++; if (n != 5) begin miscompares++; $display("FAIL store_valid_cycles: got %0d want 5", n); end
    vectors++; if (bad != 0) begin miscompares++; $display("FAIL store_data_stable: got %0d bad cycles want 0", bad); end
    vectors++; if (store_valid !== 1'b0 || cmd_ready !== 1'b1) begin miscompares++; $display("FAIL store_done_idle: got valid=%b ready=%b want 0/1", store_valid, cmd_ready); end
    vectors++; if (xfer_count !== 8'd5) begin miscompares++; $display("FAIL store_count: got %0d want 5", xfer_count); end
  endtask

  task automatic test_timeout();
    int n, bad;
    issue(STORE, 3'd6, 3'd0, 8'h00);
    @(negedge clock);
    wait_store(0, 8'h3C, n, bad);
    vectors++; if (n != 15) begin miscompares++; $display("FAIL tmo_cycles: got %0d want 15", n); end
    vectors++; if (timeout_err !== 1'b1) begin miscompares++; $display("FAIL tmo_err_set: got %b want 1", timeout_err); end
    vectors++; if (xfer_count !== 8'd5 || cmd_ready !== 1'b1) begin miscompares++; $display("FAIL tmo_no_count: got cnt=%0d ready=%b want 5/1", xfer_count, cmd_ready); end
    repeat (3) @(negedge clock);
    vectors++; if (timeout_err !== 1'b1) begin miscompares++; $display("FAIL tmo_err_sticky: got %b want 1", timeout_err); end
    err_clear = 1'b1;
    @(negedge clock);
    err_clear = 1'b0;
    vectors++; if (timeout_err !== 1'b0) begin miscompares++; $display("FAIL tmo_err_clear: got %b want 0", timeout_err); end
  endtask

  task automatic test_timeout_edges();
    int n, bad;
    issue(STORE, 3'd6, 3'd0, 8'h00);
    @(negedge clock);
    wait_store(15, 8'h3C, n, bad);
    vectors++; if (n != 15 || timeout_err !== 1'b0) begin miscompares++; $display("FAIL tmo_last_ready: got n=%0d err=%b want 15/0", n, timeout_err); end
    vectors++; if (xfer_count !== 8'd6) begin miscompares++; $display("FAIL tmo_last_ready_count: got %0d want 6", xfer_count); end
    err_clear = 1'b1;
    issue(STORE, 3'd6, 3'd0, 8'h00);
    @(negedge clock);
    wait_store(0, 8'h3C, n, bad);
    vectors++; if (timeout_err !== 1'b1) begin miscompares++; $display("FAIL tmo_set_beats_clear: got %b want 1", timeout_err); end
    @(negedge clock);
    err_clear = 1'b0;
    vectors++; if (timeout_err !== 1'b0 || xfer_count !== 8'd6) begin miscompares++; $display("FAIL tmo_clear_after: got err=%b cnt=%0d want 0/6", timeout_err, xfer_count); end
  endtask

  task automatic test_back_to_back();
    int bad = 0;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    cmd_op = LOADI; cmd_src = 3'd0; cmd_valid = 1'b1;
    for (int i = 0; i < 256; i++) begin
      cmd_dst = i[2:0]; cmd_imm = i[7:0];
      if (cmd_ready !== 1'b1) bad++;
      if (i == 255) begin
        vectors++; if (xfer_count !== 8'hFF) begin miscompares++; $display("FAIL b2b_count_255: got %h want ff", xfer_count); end
      end
      @(negedge clock);
      if (cmd_ready !== 1'b0 || read_data !== 1'b1 || data_bus !== i[7:0]) bad++;
      if (i == 255) cmd_valid = 1'b0;
      @(negedge clock);
    end
    vectors++; if (bad != 0) begin miscompares++; $display("FAIL b2b_toggle: got %0d bad cycles want 0", bad); end
    vectors++; if (xfer_count !== 8'h00) begin miscompares++; $display("FAIL b2b_wrap: got %h want 00", xfer_count); end
    vectors++; if (regs[0] !== 8'hF8 || regs[7] !== 8'hFF) begin miscompares++; $display("FAIL b2b_regs: got %h/%h want f8/ff", regs[0], regs[7]); end
  endtask

  task automatic test_reset_mid_store();
    int n, bad;
    issue(STORE, 3'd7, 3'd0, 8'h00);
    @(negedge clock);
    wait_store(0, 8'hFF, n, bad);
    issue(LOADI, 3'd0, 3'd2, 8'h5A);
    @(negedge clock);
    issue(STORE, 3'd7, 3'd0, 8'h00);
    @(negedge clock);
    @(negedge clock);
    vectors++; if (store_valid !== 1'b1 || store_data !== 8'hFF || timeout_err !== 1'b1 || xfer_count !== 8'd1) begin miscompares++; $display("FAIL mid_pre: got v=%b d=%h e=%b c=%0d want 1/ff/1/1", store_valid, store_data, timeout_err, xfer_count); end
    #2 reset = 1'b1;
    #1;
    vectors++; if (store_valid !== 1'b0 || store_data !== 8'h00) begin miscompares++; $display("FAIL mid_rst_store: got v=%b d=%h want 0/00", store_valid, store_data); end
    vectors++; if (xfer_count !== 8'h00 || timeout_err !== 1'b0) begin miscompares++; $display("FAIL mid_rst_regs: got cnt=%h err=%b want 00/0", xfer_count, timeout_err); end
    vectors++; if (data_bus !== 8'h00 || write_data !== 1'b0 || read_data !== 1'b0) begin miscompares++; $display("FAIL mid_rst_bus: got bus=%h wr=%b rd=%b want 00/0/0", data_bus, write_data, read_data); end
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    vectors++; if (cmd_ready !== 1'b1 || store_valid !== 1'b0) begin miscompares++; $display("FAIL mid_rst_release: got ready=%b valid=%b want 1/0", cmd_ready, store_valid); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_loadi();
    test_nop();
    test_mov();
    test_store();
    test_timeout();
    test_timeout_edges();
    test_back_to_back();
    test_reset_mid_store();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bus_sequencer.md
BUS_SEQUENCER -- requirements
Module: bus_sequencer

Interface
REQ-001 Parameter STORE_TIMEOUT, default 15: max cycles spent in STORE_WAIT before the store is abandoned.
REQ-002 Parameter CNT_W, default 8: width of xfer_count.
REQ-003 clock  in  1  single clock; all state changes on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 cmd_valid  in  1  command present.
REQ-006 cmd_ready  out  1  sequencer accepts a command this cycle.
REQ-007 cmd_op  in  2  00 NOP, 01 LOADI, 10 MOV, 11 STORE.
REQ-008 cmd_src  in  3  source register index (MOV, STORE).
REQ-009 cmd_dst  in  3  destination register index (LOADI, MOV).
REQ-010 cmd_imm  in  8  immediate value (LOADI).
REQ-011 read_data  out  1  to register file: load register input_select from data_bus.
REQ-012 write_data  out  1  to register file: drive register output_select onto data_bus.
REQ-013 input_select  out  3  destination register index.
REQ-014 output_select  out  3  source register index.
REQ-015 data_bus  inout  8  shared bus; driven by this block only during LOADI execution, else hi-Z.
REQ-016 store_valid  out  1  store_data holds a stored register value.
REQ-017 store_data  out  8  captured register value.
REQ-018 store_ready  in  1  downstream consumes store_data.
REQ-019 err_clear  in  1  clears timeout_err.
REQ-020 timeout_err  out  1  sticky: a store was abandoned.
REQ-021 xfer_count  out  CNT_W  completed LOADI/MOV/STORE count.

Function
REQ-022 FSM states: IDLE, EXEC, STORE_WAIT; all bus and select outputs SHALL be decoded from registered state and the latched command only (no combinational path from cmd_* inputs).
REQ-023 cmd_ready SHALL be 1 only in IDLE; a command is accepted on a rising edge with cmd_valid=1 and cmd_ready=1; op/src/dst/imm are latched; next state EXEC.
REQ-024 EXEC lasts exactly one cycle.
REQ-025 EXEC/LOADI: data_bus=imm, read_data=1, input_select=dst, write_data=0; next IDLE.
REQ-026 EXEC/MOV: write_data=1, output_select=src, read_data=1, input_select=dst, data_bus hi-Z from this block; next IDLE; src==dst executes normally.
REQ-027 EXEC/STORE: write_data=1, output_select=src, read_data=0; data_bus sampled into store_data at the closing edge; next STORE_WAIT.
REQ-028 EXEC/NOP: no strobes; next IDLE; xfer_count unchanged.
REQ-029 This block SHALL never drive data_bus while write_data=1; outside LOADI-EXEC, read_data=write_data=0 and data_bus is hi-Z.
REQ-030 STORE_WAIT: store_valid=1, store_data stable; edge with store_ready=1 -> IDLE, store_valid 0 next cycle.
REQ-031 Timeout counter starts at 0 on entry to STORE_WAIT, increments each cycle without store_ready; on the edge where it would reach STORE_TIMEOUT -> IDLE, store dropped, timeout_err set; store_ready in that same cycle wins (completes normally, no error).
REQ-032 xfer_count increments by 1 on EXEC exit for LOADI/MOV and on STORE_WAIT exit with store_ready; wraps modulo 2^CNT_W; abandoned stores do not count.
REQ-033 err_clear=1 clears timeout_err at the next edge; simultaneous set and clear -> set wins.
REQ-034 Throughput: LOADI/MOV one per 2 cycles; register file updated at the edge ending EXEC (2 edges after acceptance).

Reset
REQ-035 reset=1 SHALL immediately force IDLE, read_data=0, write_data=0, selects=0, data_bus hi-Z, store_valid=0, store_data=0x00, timeout_err=0, xfer_count=0, timeout counter 0.
REQ-036 Reset during EXEC or STORE_WAIT aborts the command with no count; cmd_ready=1 the first cycle after reset deasserts.

Verification
REQ-037 LOADI dst=3 imm=0xA5 -> one EXEC cycle with data_bus=0xA5, read_data=1, input_select=3; register 3 reads 0xA5; xfer_count=1.
REQ-038 LOADI r1=0x3C, then MOV src=1 dst=6 -> EXEC shows write_data=read_data=1, selects 1/6; register 6 = 0x3C; data_bus never double-driven.
REQ-039 STORE src=6 with store_ready held 0 for 4 cycles then 1 -> store_valid=1 with store_data=0x3C for 5 cycles; IDLE after; xfer_count +1.
REQ-040 STORE with store_ready stuck 0 -> return to IDLE after STORE_TIMEOUT=15 cycles, timeout_err=1, count unchanged; err_clear pulse -> timeout_err=0.
REQ-041 CNT_W=8, 256 LOADIs back-to-back with cmd_valid held 1 -> xfer_count wraps to 0x00; cmd_ready toggles every cycle.
REQ-042 Assert reset mid-STORE_WAIT -> store_valid, store_data, xfer_count, timeout_err all 0 asynchronously; data_bus hi-Z.
